// File: rtl/seri_pkg.sv
// Shared frame definitions for the serial transmitter/receiver pair.
package seri_pkg;

  localparam int DATA_W_VARSAYILAN = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } statetype;

endpackage

// File: rtl/seri_alici.sv
// Serial frame receiver: start/DATA_W bits LSB first/stop, valid/ack output, framing + overrun flags.
// Optional saturating framing-error counter on port hata_sayisi under SERI_ALICI_HATA_SAYAC_EN.
module seri_alici
  import seri_pkg::*;
#(
  parameter int DATA_W = DATA_W_VARSAYILAN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seri_giris,
  output logic [DATA_W-1:0] veri,
  output logic              hazir,
  input  logic              oku,
  output logic              mesgul,
  output logic              cerceve_hata,
`ifdef SERI_ALICI_HATA_SAYAC_EN
  output logic              tasma,
  output logic [7:0]        hata_sayisi
`else
  output logic              tasma
`endif
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  statetype          st, st_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (!seri_giris) st_nxt = DATA;
      DATA:    if (cnt == CW'(DATA_W - 1)) st_nxt = STOP;
      STOP:    st_nxt = seri_giris ? IDLE : BREAK;
      BREAK:   if (seri_giris) st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st           <= IDLE;
      cnt          <= '0;
      shreg        <= '0;
      veri         <= '0;
      hazir        <= 1'b0;
      mesgul       <= 1'b0;
      cerceve_hata <= 1'b0;
      tasma        <= 1'b0;
    end else begin
      st           <= st_nxt;
      mesgul       <= (st_nxt == DATA) || (st_nxt == STOP);
      cerceve_hata <= 1'b0;
      // Consumer ack; a completing frame below may re-raise hazir in the same cycle.
      if (oku && hazir) begin
        hazir <= 1'b0;
        tasma <= 1'b0;
      end
      case (st)
        IDLE: cnt <= '0;
        DATA: begin
          shreg[cnt] <= seri_giris;
          cnt        <= cnt + 1'b1;
        end
        STOP: begin
          if (seri_giris) begin
            if (!hazir || oku) begin
              veri  <= shreg;
              hazir <= 1'b1;
            end else begin
              tasma <= 1'b1;
            end
          end else begin
            cerceve_hata <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERI_ALICI_HATA_SAYAC_EN
  always_ff @(posedge clk) begin
    if (!reset)
      hata_sayisi <= '0;
    else if (st == STOP && !seri_giris && hata_sayisi != 8'hFF)
      hata_sayisi <= hata_sayisi + 8'd1;
  end
`endif

endmodule

// File: tb/tb_seri_alici.sv
// Directed + random frame stimulus for seri_alici against a frame-level reference model.
module tb_seri_alici;
  logic       clk = 1'b0;
  logic       reset;
  logic       seri_giris;
  logic [4:0] veri;
  logic       hazir;
  logic       oku;
  logic       mesgul;
  logic       cerceve_hata;
  logic       tasma;
`ifdef SERI_ALICI_HATA_SAYAC_EN
  logic [7:0] hata_sayisi;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: what a consumer should see after each clock.
  logic [4:0] m_veri;
  logic       m_hazir;
  logic       m_tasma;
  int         m_hata;

  always #5 clk = ~clk;

  seri_alici #(.DATA_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .seri_giris   (seri_giris),
    .veri         (veri),
    .hazir        (hazir),
    .oku          (oku),
    .mesgul       (mesgul),
    .cerceve_hata (cerceve_hata),
`ifdef SERI_ALICI_HATA_SAYAC_EN
    .tasma        (tasma),
    .hata_sayisi  (hata_sayisi)
`else
    .tasma        (tasma)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic exp_cerc);
    chk({tag, ".veri"},  veri,  m_veri);
    chk({tag, ".hazir"}, hazir, m_hazir);
    chk({tag, ".tasma"}, tasma, m_tasma);
    chk({tag, ".cerceve_hata"}, cerceve_hata, exp_cerc);
`ifdef SERI_ALICI_HATA_SAYAC_EN
    chk({tag, ".hata_sayisi"}, hata_sayisi, m_hata);
`endif
  endtask

  // One full frame; ok is the consumer ack driven during the stop-bit cycle.
  task automatic send(input string tag, input logic [4:0] d, input logic stopb, input logic ok);
    seri_giris = 1'b0;
    oku        = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk({tag, ".mesgul_data"}, mesgul, 1'b1);
      seri_giris = d[i];
      step();
    end
    chk({tag, ".mesgul_stop"}, mesgul, 1'b1);
    seri_giris = stopb;
    oku        = ok;
    step();
    oku        = 1'b0;
    seri_giris = 1'b1;
    if (stopb) begin
      if (!m_hazir || ok) begin
        m_veri  = d;
        m_hazir = 1'b1;
        if (ok) m_tasma = 1'b0;
      end else begin
        m_tasma = 1'b1;
      end
    end else begin
      m_hata = (m_hata < 255) ? m_hata + 1 : 255;
      if (ok && m_hazir) begin
        m_hazir = 1'b0;
        m_tasma = 1'b0;
      end
    end
    chk_outputs(tag, !stopb);
    chk({tag, ".mesgul_end"}, mesgul, 1'b0);
  endtask

  // Idle-line cycles, optionally acking on each.
  task automatic idle(input string tag, input int n, input logic ok);
    for (int i = 0; i < n; i++) begin
      seri_giris = 1'b1;
      oku        = ok;
      step();
      oku = 1'b0;
      if (ok && m_hazir) begin
        m_hazir = 1'b0;
        m_tasma = 1'b0;
      end
      chk_outputs(tag, 1'b0);
      chk({tag, ".mesgul"}, mesgul, 1'b0);
    end
  endtask

  initial begin
    logic [4:0] d;
    logic       sb, ok;
    int         gap;

    // Reset with toggling line
    reset = 1'b0; oku = 1'b0; seri_giris = 1'b0;
    m_veri = '0; m_hazir = 1'b0; m_tasma = 1'b0; m_hata = 0;
    step(); seri_giris = 1'b1;
    step(); seri_giris = 1'b0;
    chk_outputs("reset", 1'b0);
    chk("reset.mesgul", mesgul, 1'b0);
    seri_giris = 1'b1;
    reset = 1'b1;
    idle("post_reset", 2, 1'b0);

    // Good frame
    send("good", 5'b10110, 1'b1, 1'b0);
    idle("good_idle", 1, 1'b0);

    // Overrun then ack
    idle("pre_ovr", 1, 1'b1);
    send("ovr1", 5'b00001, 1'b1, 1'b0);
    send("ovr2", 5'b11111, 1'b1, 1'b0);
    idle("ovr_ack", 1, 1'b1);
    idle("ovr_after", 1, 1'b0);

    // Ack coincident with completion, while a word is held
    send("same_a", 5'b00111, 1'b1, 1'b0);
    send("same_b", 5'b01010, 1'b1, 1'b1);

    // Framing error, held-low line must not start a frame
    send("ferr", 5'b11111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      seri_giris = 1'b0;
      step();
      chk_outputs("break", 1'b0);
      chk("break.mesgul", mesgul, 1'b0);
    end
    idle("break_end", 3, 1'b0);

    // Back-to-back frames with one idle cycle, then reset mid-frame
    idle("b2b_ack", 1, 1'b1);
    send("b2b1", 5'b10011, 1'b1, 1'b0);
    idle("b2b_gap", 1, 1'b1);
    send("b2b2", 5'b01101, 1'b1, 1'b0);
    idle("b2b_gap2", 1, 1'b0);
    d = 5'b00100;
    seri_giris = 1'b0; step();
    seri_giris = d[0]; step();
    seri_giris = d[1]; step();
    seri_giris = d[2]; reset = 1'b0; step();
    reset = 1'b1; seri_giris = 1'b1;
    m_veri = '0; m_hazir = 1'b0; m_tasma = 1'b0; m_hata = 0;
    chk_outputs("midreset", 1'b0);
    chk("midreset.mesgul", mesgul, 1'b0);
    idle("midreset_idle", 8, 1'b0);

    // Random frames, gaps and acks
    sb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      d   = 5'($urandom);
      ok  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      if (!sb && gap == 0) gap = 1;
      idle("rnd_idle", gap, 1'($urandom_range(0, 1)));
      sb = ($urandom_range(0, 5) != 0);
      send("rnd", d, sb, ok);
    end
    idle("rnd_tail", 2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
